axil_mem_slave: RTL
===================

AXIL_MEM_SLAVE -- requirements
Module: axil_mem_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI4-Lite address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width; only 32 is supported.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0, first byte address served.
REQ-004 SHALL have parameter DEPTH_WORDS, default 16384, number of 32-bit memory words; must be a power of 2.
REQ-005 Ports SHALL be, in order:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- aw_addr  in  ADDR_W  write address.
- aw_valid in 1; aw_ready out 1.
- w_data  in  32  write data.
- w_strb  in  4  byte enables.
- w_valid in 1; w_ready out 1.
- b_resp  out  2  write response.
- b_valid out 1; b_ready in 1.
- ar_addr  in  ADDR_W  read address.
- ar_valid in 1; ar_ready out 1.
- r_data  out  32  read data.
- r_resp  out  2  read response.
- r_valid out 1; r_ready in 1.

Function
REQ-006 SHALL act as the AXI4-Lite responder for one initiator, with at most one transaction (read or write) in flight.
REQ-007 FSM SHALL have states IDLE, RD_WAIT, RD_RESP and WR_RESP.
REQ-008 In IDLE, a write SHALL be pending only when aw_valid and w_valid are both 1, and a read only when ar_valid is 1.
REQ-009 When both a write and a read are pending in IDLE, grant SHALL alternate between them using a last_wr flag; after reset the write wins first.
REQ-010 A write grant SHALL assert aw_ready and w_ready in the same cycle, for that cycle only, and move to WR_RESP.
REQ-011 A read grant SHALL assert ar_ready for one cycle and move to RD_WAIT.
REQ-012 The ready outputs SHALL be 0 in every state other than IDLE; they may depend combinationally on the valid inputs.
REQ-013 Address decode:
- offset = addr - BASE_ADDR; index = offset[..:2]; addr[1:0] is ignored.
- in range when BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS.
REQ-014 In-range write SHALL update the bytes enabled by w_strb at the grant edge; w_strb=0 SHALL leave memory unchanged and still return OKAY.
REQ-015 Out-of-range write SHALL leave memory unchanged and return SLVERR (2'b10); OKAY is 2'b00.
REQ-016 In WR_RESP, b_valid SHALL be 1 with b_resp stable and held until b_ready; the state returns to IDLE on the cycle b_valid and b_ready are both 1.
REQ-017 RD_WAIT SHALL last exactly one cycle (synchronous RAM read) and then go to RD_RESP.
REQ-018 In RD_RESP, r_valid SHALL be 1 with r_data and r_resp stable and held until r_ready; the state returns to IDLE on the cycle r_valid and r_ready are both 1.
REQ-019 Out-of-range read SHALL return r_data=0 with r_resp=SLVERR.
REQ-020 Latency SHALL be:
- handshake at cycle N: b_valid at N+1 (write), r_valid at N+2 (read).
- a new grant is possible in the cycle after the response handshake.
REQ-021 A read granted after a write SHALL return the newly written data (no stale read).
REQ-022 The block SHALL never produce b_valid or r_valid without a preceding accepted request.

Reset
REQ-023 Asserting rst_n low SHALL immediately force:
- state=IDLE, last_wr=0;
- all ready, valid and resp outputs to 0, r_data=0.
REQ-024 Reset mid-transaction SHALL discard any pending response.
REQ-025 Memory contents SHALL NOT be reset.

Structure
REQ-026 Package axil_pkg SHALL hold resp_t (OKAY=2'b00, SLVERR=2'b10) and the FSM state enum.
REQ-027 Storage SHALL be a sub-module axil_sp_ram: single-port, DEPTH_WORDS x 32, per-byte write enables, 1-cycle synchronous read.
REQ-028 The block SHALL be plug-compatible, through axil_if.Slave signal names, with the imem and dmem buses of scr1_top_axi_wrap.

Verification
REQ-029 Write 0xDEADBEEF to 0x10 with strb=F, then read 0x10 -> b_resp=00 at N+1; r_data=0xDEADBEEF, r_resp=00 at N+2.
REQ-030 Write 0x11223344 to 0x20 with strb=F, then write 0xAABBCCDD with strb=0101, then read -> r_data=0x11BB33DD.
REQ-031 aw_valid, w_valid and ar_valid all held high for 4 transactions -> grants go W, R, W, R.
REQ-032 Read at BASE_ADDR + 4*DEPTH_WORDS -> r_resp=10, r_data=0; a write to the same address returns b_resp=10 and memory is unchanged.
REQ-033 r_ready held low for 5 cycles -> r_valid and r_data stay stable, ar_ready stays 0, and a new ar_valid is not accepted.
REQ-034 rst_n pulsed low in RD_RESP -> r_valid=0 immediately; after release the next read completes normally.

Source files
------------

// File: rtl/axil_pkg.sv
// AXI4-Lite memory responder: shared types.
// Response codes and FSM state encoding.
package axil_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_RESP,
        WR_RESP
    } state_t;

endpackage

// File: rtl/axil_if.sv
// AXI4-Lite bus bundle with Master/Slave views.
// Signal names match the imem/dmem buses of the core wrapper.
interface axil_if #(
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] aw_addr;
    logic              aw_valid;
    logic              aw_ready;
    logic [31:0]       w_data;
    logic [3:0]        w_strb;
    logic              w_valid;
    logic              w_ready;
    logic [1:0]        b_resp;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] ar_addr;
    logic              ar_valid;
    logic              ar_ready;
    logic [31:0]       r_data;
    logic [1:0]        r_resp;
    logic              r_valid;
    logic              r_ready;

    modport Master (
        output aw_addr, aw_valid, w_data, w_strb, w_valid,
        output b_ready, ar_addr, ar_valid, r_ready,
        input  aw_ready, w_ready, b_resp, b_valid,
        input  ar_ready, r_data, r_resp, r_valid
    );

    modport Slave (
        input  aw_addr, aw_valid, w_data, w_strb, w_valid,
        input  b_ready, ar_addr, ar_valid, r_ready,
        output aw_ready, w_ready, b_resp, b_valid,
        output ar_ready, r_data, r_resp, r_valid
    );
endinterface

// File: rtl/axil_sp_ram.sv
// Single-port RAM, per-byte write enables.
// Read data registered one cycle after the access; contents not reset.
module axil_sp_ram #(
    parameter int  DEPTH = 16384,
    parameter int  WIDTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               en,
    input  logic               we,
    input  logic [WIDTH/8-1:0] be,
    input  logic [AW-1:0]      addr,
    input  logic [WIDTH-1:0]   wdata,
    output logic [WIDTH-1:0]   rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    // Byte-masked write or registered read, one per cycle
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < WIDTH/8; b++) begin
                    if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end
endmodule

// File: rtl/axil_mem_slave.sv
// AXI4-Lite memory responder, one transaction in flight.
// Write/read arbitration alternates when both are pending.
module axil_mem_slave
    import axil_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          DATA_W      = 32,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          DEPTH_WORDS = 16384
) (
    input  logic  clk,
    input  logic  rst_n,
    axil_if.Slave bus
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   SPAN = (ADDR_W+1)'(4 * DEPTH_WORDS);

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        logic [ADDR_W:0] off;
        off = {1'b0, a} - {1'b0, BASE};
        return (a >= BASE) && (off < SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE) >> 2);
    endfunction

    state_t            state_q, state_d;
    logic              last_wr_q;
    logic              wr_pend, rd_pend;
    logic              grant_wr, grant_rd;
    logic              wr_ok, rd_ok, rd_ok_q;
    resp_t             b_resp_q, r_resp_q;
    logic [31:0]       r_data_q;
    logic [DATA_W-1:0] ram_rdata;

    // Gating with rst_n keeps readies low and the RAM idle during reset
    assign wr_pend = rst_n & bus.aw_valid & bus.w_valid;
    assign rd_pend = rst_n & bus.ar_valid;
    assign wr_ok   = in_range(bus.aw_addr);
    assign rd_ok   = in_range(bus.ar_addr);

    // Next state and grants; write wins unless it won last time
    always_comb begin
        state_d  = state_q;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (wr_pend && (!rd_pend || !last_wr_q)) begin
                    grant_wr = 1'b1;
                    state_d  = WR_RESP;
                end else if (rd_pend) begin
                    grant_rd = 1'b1;
                    state_d  = RD_WAIT;
                end
            end
            RD_WAIT: state_d = RD_RESP;
            RD_RESP: if (bus.r_ready) state_d = IDLE;
            WR_RESP: if (bus.b_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Arbitration flag and response holding registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_wr_q <= 1'b0;
            rd_ok_q   <= 1'b0;
            b_resp_q  <= RESP_OKAY;
            r_resp_q  <= RESP_OKAY;
            r_data_q  <= '0;
        end else begin
            if (grant_wr) begin
                last_wr_q <= 1'b1;
                b_resp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end
            if (grant_rd) begin
                last_wr_q <= 1'b0;
                rd_ok_q   <= rd_ok;
            end
            if (state_q == RD_WAIT) begin
                r_data_q <= rd_ok_q ? ram_rdata : '0;
                r_resp_q <= rd_ok_q ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    axil_sp_ram #(
        .DEPTH (DEPTH_WORDS),
        .WIDTH (DATA_W)
    ) u_ram (
        .clk   (clk),
        .en    ((grant_wr & wr_ok) | grant_rd),
        .we    (grant_wr & wr_ok),
        .be    (bus.w_strb),
        .addr  (grant_wr ? idx(bus.aw_addr) : idx(bus.ar_addr)),
        .wdata (bus.w_data),
        .rdata (ram_rdata)
    );

    assign bus.aw_ready = grant_wr;
    assign bus.w_ready  = grant_wr;
    assign bus.ar_ready = grant_rd;
    assign bus.b_valid  = (state_q == WR_RESP);
    assign bus.b_resp   = b_resp_q;
    assign bus.r_valid  = (state_q == RD_RESP);
    assign bus.r_resp   = r_resp_q;
    assign bus.r_data   = r_data_q;
endmodule
